// File: rtl/ripple_adder_pkg.sv
// Shared types and constants for the multi-cycle ripple adder.
package ripple_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned DEFAULT_WIDTH = 16;
    localparam int unsigned DEFAULT_CHUNK = 4;

    // Bits needed to count v distinct values (0 for v <= 1).
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((33'd1 << r) < 33'(v)) r++;
        return r;
    endfunction

endpackage

// File: rtl/multicycle_ripple_adder_if.sv
// Operand/result handshake bundle; the sub port exists only with RIPPLE_ADDER_SUB_EN.
interface multicycle_ripple_adder_if
    import ripple_adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             carry_in;
`ifdef RIPPLE_ADDER_SUB_EN
    logic             sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             busy;

`ifdef RIPPLE_ADDER_SUB_EN
    modport master (output in_valid, a, b, carry_in, sub, out_ready,
                    input  in_ready, out_valid, sum, carry_out, busy);
    modport slave  (input  in_valid, a, b, carry_in, sub, out_ready,
                    output in_ready, out_valid, sum, carry_out, busy);
`else
    modport master (output in_valid, a, b, carry_in, out_ready,
                    input  in_ready, out_valid, sum, carry_out, busy);
    modport slave  (input  in_valid, a, b, carry_in, out_ready,
                    output in_ready, out_valid, sum, carry_out, busy);
`endif

endinterface

// File: rtl/multicycle_ripple_adder_chunk_adder.sv
// Combinational CHUNK-bit ripple-carry adder slice.
module chunk_adder
    import ripple_adder_pkg::*;
#(
    parameter int unsigned CHUNK = DEFAULT_CHUNK
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             carry_in,
    output logic [CHUNK-1:0] sum,
    output logic             carry_out
);

    logic [CHUNK:0] c;

    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = carry_in;
        for (int i = 0; i < int'(CHUNK); i++) begin
            sum[i]  = a[i] ^ b[i] ^ c[i];
            c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        carry_out = c[CHUNK];
    end

endmodule

// File: rtl/multicycle_ripple_adder.sv
// WIDTH-bit adder resolving CHUNK bits per clock with a registered inter-chunk carry.
// Optional subtract mode under RIPPLE_ADDER_SUB_EN.
module multicycle_ripple_adder
    import ripple_adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned CHUNK = DEFAULT_CHUNK
) (
    input  logic                      clk,
    input  logic                      rst,
    multicycle_ripple_adder_if.slave  bus
);

    localparam int unsigned NCHUNK = (CHUNK == 0) ? 1 : WIDTH / CHUNK;
    localparam int unsigned CW     = (NCHUNK > 1) ? clog2(NCHUNK) : 1;

    generate
        if (CHUNK == 0) begin : g_bad_chunk
            $error("multicycle_ripple_adder: CHUNK must be nonzero");
        end else if ((WIDTH % CHUNK) != 0) begin : g_bad_width
            $error("multicycle_ripple_adder: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sh, b_sh, a_nxt, b_nxt, res_nxt;
    logic [WIDTH-1:0] b_ld, sum_r;
    logic             c_ld, carry_r, carry_out_r, out_valid_r;
    logic [CW-1:0]    count;
    logic [CHUNK-1:0] cs_sum;
    logic             cs_cout;
    logic             accept, last;

    assign accept = bus.in_valid && (state == IDLE);
    assign last   = (state == RUN) && (count == CW'(NCHUNK - 1));

`ifdef RIPPLE_ADDER_SUB_EN
    // Subtract as a + ~b + 1; carry_in has no effect in that mode.
    assign b_ld = bus.sub ? ~bus.b : bus.b;
    assign c_ld = bus.sub | bus.carry_in;
`else
    assign b_ld = bus.b;
    assign c_ld = bus.carry_in;
`endif

    chunk_adder #(.CHUNK(CHUNK)) u_chunk (
        .a         (a_sh[CHUNK-1:0]),
        .b         (b_sh[CHUNK-1:0]),
        .carry_in  (carry_r),
        .sum       (cs_sum),
        .carry_out (cs_cout)
    );

    // Operand shift and result assembly; a single chunk needs no shift register.
    generate
        if (NCHUNK == 1) begin : g_single
            assign res_nxt = cs_sum;
            assign a_nxt   = '0;
            assign b_nxt   = '0;
        end else begin : g_multi
            logic [WIDTH-1:0] res_sh;

            assign res_nxt = {cs_sum, res_sh[WIDTH-1:CHUNK]};
            assign a_nxt   = {{CHUNK{1'b0}}, a_sh[WIDTH-1:CHUNK]};
            assign b_nxt   = {{CHUNK{1'b0}}, b_sh[WIDTH-1:CHUNK]};

            always_ff @(posedge clk or posedge rst) begin
                if (rst)                res_sh <= '0;
                else if (state == RUN)  res_sh <= res_nxt;
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept)        state_nxt = RUN;
            RUN:     if (last)          state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh        <= '0;
            b_sh        <= '0;
            carry_r     <= 1'b0;
            count       <= '0;
            sum_r       <= '0;
            carry_out_r <= 1'b0;
            out_valid_r <= 1'b0;
        end else if (accept) begin
            a_sh    <= bus.a;
            b_sh    <= b_ld;
            carry_r <= c_ld;
            count   <= '0;
        end else if (state == RUN) begin
            a_sh    <= a_nxt;
            b_sh    <= b_nxt;
            carry_r <= cs_cout;
            count   <= count + CW'(1);
            if (last) begin
                sum_r       <= res_nxt;
                carry_out_r <= cs_cout;
                out_valid_r <= 1'b1;
            end
        end else if ((state == DONE) && bus.out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.busy      = (state != IDLE);
    assign bus.out_valid = out_valid_r;
    assign bus.sum       = sum_r;
    assign bus.carry_out = carry_out_r;

endmodule
